// File: rtl/bus_cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU, bus encoder,
// CON flip-flop and RAM (initially zero).
module bus_cpu_datapath #(
    parameter int unsigned MEM_DEPTH = 512,
    parameter logic [4:0]  BRANCH_OP = 5'b10010
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        Zin,
    input  logic        Yin,
    input  logic        MARin,
    input  logic        IRin,
    input  logic        CONin,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        ZHIout,
    input  logic        ZLOout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        INPORTout,
    input  logic        Cout,
    input  logic        Yout,
    input  logic        OUTPORTout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Read,
    input  logic        write,
    input  logic        IncPC,
    input  logic [31:0] inportInput,
    input  logic [15:0] regIn,
    output logic [31:0] busMuxOut,
    output logic [4:0]  encoderOut,
    output logic        CON,
    output logic [31:0] BusMuxInR0,
    output logic [31:0] BusMuxInR1,
    output logic [31:0] BusMuxInR2,
    output logic [31:0] BusMuxInR3,
    output logic [31:0] BusMuxInR4,
    output logic [31:0] BusMuxInR5,
    output logic [31:0] BusMuxInR6,
    output logic [31:0] BusMuxInR7,
    output logic [31:0] BusMuxInR8,
    output logic [31:0] BusMuxInR9,
    output logic [31:0] BusMuxInR10,
    output logic [31:0] BusMuxInR11,
    output logic [31:0] BusMuxInR12,
    output logic [31:0] BusMuxInR13,
    output logic [31:0] BusMuxInR14,
    output logic [31:0] BusMuxInR15,
    output logic [31:0] BusMuxInHI,
    output logic [31:0] BusMuxInLO,
    output logic [31:0] BusMuxInZhi,
    output logic [31:0] BusMuxInZlo,
    output logic [31:0] BusMuxInPC,
    output logic [31:0] BusMuxInMDR,
    output logic [31:0] BusMuxInInport,
    output logic [31:0] BusMuxInOutport,
    output logic [31:0] BusMuxInY,
    output logic [31:0] IRregister,
    output logic [31:0] Cregister,
    output logic [8:0]  marToRam
);

    localparam int unsigned AddrW = $clog2(MEM_DEPTH);

    logic [31:0] r_q [16];
    logic [31:0] hi_q, lo_q, pc_q, ir_q, y_q, mdr_q, inport_q, outport_q;
    logic [8:0]  mar_q;
    logic [63:0] z_q;
    logic        con_q;

    logic [3:0]  reg_field;
    logic [15:0] reg_sel, r_load, r_drive;
    logic [24:0] src_req;
    logic [4:0]  enc_code;
    logic [31:0] bus, c_sext, mem_rd;
    logic [63:0] alu_z, mul_a, mul_b;
    logic        con_cond;

    logic [31:0] mem [MEM_DEPTH] = '{default: '0};

    // Register select: OR of the strobed IR fields, decoded one-hot.
    assign reg_field = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19])
                     | ({4{Grc}} & ir_q[18:15]);
    assign reg_sel   = 16'd1 << reg_field;
    assign r_load    = regIn | ({16{Rin}} & reg_sel);
    assign r_drive   = {16{Rout | BAout}} & reg_sel;
    assign c_sext    = {{13{ir_q[18]}}, ir_q[18:0]};
    assign mem_rd    = mem[mar_q[AddrW-1:0]];

    always_comb begin
        src_req  = {Yout, Cout, INPORTout, MDRout, PCout, ZLOout, ZHIout, LOout, HIout,
                    r_drive};
        enc_code = 5'd19;  // Zlo drives an otherwise idle bus
        for (int i = 24; i >= 0; i--) begin
            if (src_req[i]) enc_code = 5'(i);
        end
    end

    always_comb begin
        case (enc_code)
            5'd16:   bus = hi_q;
            5'd17:   bus = lo_q;
            5'd18:   bus = z_q[63:32];
            5'd19:   bus = z_q[31:0];
            5'd20:   bus = pc_q;
            5'd21:   bus = mdr_q;
            5'd22:   bus = inport_q;
            5'd23:   bus = c_sext;
            5'd24:   bus = y_q;
            default: bus = (BAout && enc_code == 5'd0) ? '0 : r_q[enc_code[3:0]];
        endcase
    end

    always_comb begin
        mul_a = {{32{y_q[31]}}, y_q};
        mul_b = {{32{bus[31]}}, bus};
        alu_z = '0;
        if (IncPC) begin
            alu_z[31:0] = bus + 32'd1;
        end else if (ir_q[31:27] == BRANCH_OP) begin
            alu_z[31:0] = y_q + (con_q ? bus : 32'd0);
        end else begin
            case (ir_q[31:27])
                5'b00100: alu_z[31:0] = y_q - bus;
                5'b00101: alu_z[31:0] = y_q & bus;
                5'b00110: alu_z[31:0] = y_q | bus;
                5'b00111: alu_z[31:0] = y_q >> bus[4:0];
                5'b01000: alu_z[31:0] = y_q << bus[4:0];
                5'b01001: alu_z[31:0] = 32'd0 - bus;
                5'b01010: alu_z[31:0] = ~bus;
                5'b01011: alu_z       = mul_a * mul_b;  // low 64 bits == signed product
                default:  alu_z[31:0] = y_q + bus;
            endcase
        end
    end

    always_comb begin
        case (ir_q[20:19])
            2'b00:   con_cond = (bus == 32'd0);
            2'b01:   con_cond = (bus != 32'd0);
            2'b10:   con_cond = ~bus[31];
            default: con_cond = bus[31];
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            z_q       <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_load[i]) r_q[i] <= bus;
            end
            if (HIin)       hi_q      <= bus;
            if (LOin)       lo_q      <= bus;
            if (PCin)       pc_q      <= bus;
            if (IRin)       ir_q      <= bus;
            if (Yin)        y_q       <= bus;
            if (MARin)      mar_q     <= bus[8:0];
            if (MDRin)      mdr_q     <= Read ? mem_rd : bus;
            if (Zin)        z_q       <= alu_z;
            if (OUTPORTout) outport_q <= bus;
            if (CONin)      con_q     <= con_cond;
            inport_q <= inportInput;
        end
    end

    always_ff @(posedge Clock) begin
        if (write) mem[mar_q[AddrW-1:0]] <= mdr_q;
    end

    assign busMuxOut       = bus;
    assign encoderOut      = enc_code;
    assign CON             = con_q;
    assign BusMuxInR0      = r_q[0];
    assign BusMuxInR1      = r_q[1];
    assign BusMuxInR2      = r_q[2];
    assign BusMuxInR3      = r_q[3];
    assign BusMuxInR4      = r_q[4];
    assign BusMuxInR5      = r_q[5];
    assign BusMuxInR6      = r_q[6];
    assign BusMuxInR7      = r_q[7];
    assign BusMuxInR8      = r_q[8];
    assign BusMuxInR9      = r_q[9];
    assign BusMuxInR10     = r_q[10];
    assign BusMuxInR11     = r_q[11];
    assign BusMuxInR12     = r_q[12];
    assign BusMuxInR13     = r_q[13];
    assign BusMuxInR14     = r_q[14];
    assign BusMuxInR15     = r_q[15];
    assign BusMuxInHI      = hi_q;
    assign BusMuxInLO      = lo_q;
    assign BusMuxInZhi     = z_q[63:32];
    assign BusMuxInZlo     = z_q[31:0];
    assign BusMuxInPC      = pc_q;
    assign BusMuxInMDR     = mdr_q;
    assign BusMuxInInport  = inport_q;
    assign BusMuxInOutport = outport_q;
    assign BusMuxInY       = y_q;
    assign IRregister      = ir_q;
    assign Cregister       = c_sext;
    assign marToRam        = mar_q;

endmodule

// File: tb/tb_bus_cpu_datapath.sv
// Directed bench for bus_cpu_datapath: ALU vector table plus hand-written fetch/branch,
// encoder, memory and reset sequences.
module tb_bus_cpu_datapath;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin;
    logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout;
    logic        OUTPORTout, Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC;
    logic [31:0] inportInput;
    logic [15:0] regIn;
    logic [31:0] busMuxOut;
    logic [4:0]  encoderOut;
    logic        CON;
    logic [31:0] r [16];
    logic [31:0] hi, lo, zhi, zlo, pc, mdr, inport, outport, y, ir, creg;
    logic [8:0]  mar;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] Instr = 32'h9310_0019;  // brpl R6,25

    bus_cpu_datapath dut (
        .Clock(Clock), .Clear(Clear),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .IRin(IRin), .CONin(CONin),
        .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
        .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout), .Yout(Yout),
        .OUTPORTout(OUTPORTout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Read(Read), .write(write), .IncPC(IncPC),
        .inportInput(inportInput), .regIn(regIn),
        .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
        .BusMuxInR0(r[0]), .BusMuxInR1(r[1]), .BusMuxInR2(r[2]), .BusMuxInR3(r[3]),
        .BusMuxInR4(r[4]), .BusMuxInR5(r[5]), .BusMuxInR6(r[6]), .BusMuxInR7(r[7]),
        .BusMuxInR8(r[8]), .BusMuxInR9(r[9]), .BusMuxInR10(r[10]), .BusMuxInR11(r[11]),
        .BusMuxInR12(r[12]), .BusMuxInR13(r[13]), .BusMuxInR14(r[14]),
        .BusMuxInR15(r[15]),
        .BusMuxInHI(hi), .BusMuxInLO(lo), .BusMuxInZhi(zhi), .BusMuxInZlo(zlo),
        .BusMuxInPC(pc), .BusMuxInMDR(mdr), .BusMuxInInport(inport),
        .BusMuxInOutport(outport), .BusMuxInY(y),
        .IRregister(ir), .Cregister(creg), .marToRam(mar)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] zhi;
        logic [31:0] zlo;
    } alu_vec_t;

    alu_vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin} = '0;
        {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout} = '0;
        {OUTPORTout, Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC} = '0;
        regIn = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    // Latch v into the inport, then leave it driving the bus for the caller's load strobe.
    task automatic via_inport(input logic [31:0] v);
        inportInput = v;
        tick();
        INPORTout = 1'b1;
    endtask

    task automatic run_branch(input logic exp_con, input logic [31:0] exp_pc);
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        check("t0_mar", 64'(mar), 64'd11);
        check("t0_zlo", 64'(zlo), 64'd12);
        Read = 1; MDRin = 1; PCin = 1; tick();
        check("t1_pc", 64'(pc), 64'd12);
        check("t1_mdr", 64'(mdr), 64'(Instr));
        MDRout = 1; IRin = 1; tick();
        check("t2_ir", 64'(ir), 64'(Instr));
        check("t2_c", 64'(creg), 64'd25);
        Gra = 1; Rout = 1; CONin = 1; tick();
        check("t3_con", 64'(CON), 64'(exp_con));
        PCout = 1; Yin = 1; tick();
        check("t4_y", 64'(y), 64'd12);
        Cout = 1; Zin = 1; tick();
        check("t5_zlo", 64'(zlo), 64'(exp_pc));
        ZLOout = 1; PCin = 1; tick();
        check("t6_pc", 64'(pc), 64'(exp_pc));
    endtask

    initial begin
        vecs[0]  = '{5'b00011, 32'd5,          32'd7,          32'h0,        32'd12};
        vecs[1]  = '{5'b00100, 32'd5,          32'd7,          32'h0,        32'hFFFF_FFFE};
        vecs[2]  = '{5'b00101, 32'h0000_F0F0,  32'h0000_FF00,  32'h0,        32'h0000_F000};
        vecs[3]  = '{5'b00110, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0,        32'h0000_FFFF};
        vecs[4]  = '{5'b00111, 32'h8000_0000,  32'h0000_0024,  32'h0,        32'h0800_0000};
        vecs[5]  = '{5'b01000, 32'd1,          32'd31,         32'h0,        32'h8000_0000};
        vecs[6]  = '{5'b01001, 32'd9,          32'd1,          32'h0,        32'hFFFF_FFFF};
        vecs[7]  = '{5'b01010, 32'd9,          32'h0000_FFFF,  32'h0,        32'hFFFF_0000};
        vecs[8]  = '{5'b01011, 32'hFFFF_FFFD,  32'd4,          32'hFFFF_FFFF, 32'hFFFF_FFF4};
        vecs[9]  = '{5'b01011, 32'h0001_0000,  32'h0001_0000,  32'h1,        32'h0};
        vecs[10] = '{5'b00000, 32'd1,          32'd2,          32'h0,        32'd3};
        vecs[11] = '{5'b00011, 32'hFFFF_FFFF,  32'd1,          32'h0,        32'h0};

        idle();
        inportInput = '0;
        Clear = 1'b1;
        tick();
        tick();
        Clear = 1'b0;
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_ir", 64'(ir), 64'd0);
        check("rst_con", 64'(CON), 64'd0);
        check("rst_zlo", 64'(zlo), 64'd0);

        // Inport to PC
        via_inport(32'd11);
        PCin = 1;
        #1;
        check("inport_bus", 64'(busMuxOut), 64'd11);
        check("inport_enc", 64'(encoderOut), 64'd22);
        tick();
        check("inport_pc", 64'(pc), 64'd11);

        // Direct register loads
        via_inport(32'h55); regIn = 16'h0060; tick();
        via_inport(32'h0);  regIn = 16'h0040; tick();
        check("regin_r6", 64'(r[6]), 64'd0);
        check("regin_r5", 64'(r[5]), 64'h55);
        check("regin_pc", 64'(pc), 64'd11);

        // Store the branch instruction at RAM[11]
        via_inport(Instr); MDRin = 1; tick();
        via_inport(32'd11); MARin = 1; tick();
        write = 1; tick();

        run_branch(1'b1, 32'd37);

        via_inport(32'h8000_0000); regIn = 16'h0040; tick();
        via_inport(32'd11); PCin = 1; tick();
        run_branch(1'b0, 32'd12);

        // HI/LO, outport, encoder priority
        via_inport(32'h1234); HIin = 1; tick();
        check("hi", 64'(hi), 64'h1234);
        HIout = 1; OUTPORTout = 1; tick();
        check("outport", 64'(outport), 64'h1234);
        via_inport(32'hABCD); LOin = 1; tick();
        LOout = 1; Yin = 1; tick();
        check("lo_to_y", 64'(y), 64'hABCD);
        HIout = 1; LOout = 1; #1;
        check("enc_hi_lo", 64'(encoderOut), 64'd16);
        check("bus_hi_lo", 64'(busMuxOut), 64'h1234);
        idle(); #1;
        check("enc_none", 64'(encoderOut), 64'd19);
        check("bus_none", 64'(busMuxOut), 64'd12);
        Cout = 1; Yout = 1; #1;
        check("enc_c_y", 64'(encoderOut), 64'd23);
        check("bus_c_y", 64'(busMuxOut), 64'd25);
        idle(); Yout = 1; #1;
        check("enc_y", 64'(encoderOut), 64'd24);
        idle();

        // BAout forces R0 to read as zero
        via_inport(32'h99); regIn = 16'h0001; tick();
        via_inport(32'h0); IRin = 1; tick();
        Gra = 1; BAout = 1; #1;
        check("baout_bus", 64'(busMuxOut), 64'd0);
        check("baout_enc", 64'(encoderOut), 64'd0);
        BAout = 0; Rout = 1; #1;
        check("rout_r0", 64'(busMuxOut), 64'h99);
        idle();

        via_inport(32'h0004_0000); IRin = 1; tick();
        check("c_sext", 64'(creg), 64'hFFFF_FFFF_FFFC_0000 & 64'hFFFF_FFFF);

        for (int i = 0; i < 12; i++) begin
            via_inport({vecs[i].op, 27'd0}); IRin = 1; tick();
            via_inport(vecs[i].a); Yin = 1; tick();
            via_inport(vecs[i].b); Zin = 1; tick();
            check($sformatf("alu%0d_zhi", i), 64'(zhi), 64'(vecs[i].zhi));
            check($sformatf("alu%0d_zlo", i), 64'(zlo), 64'(vecs[i].zlo));
        end

        // Memory write/readback and read-during-write
        via_inport(32'd5); MARin = 1; tick();
        via_inport(32'hDEAD); MDRin = 1; tick();
        write = 1; tick();
        via_inport(32'h0); MDRin = 1; tick();
        check("mdr_cleared", 64'(mdr), 64'd0);
        Read = 1; MDRin = 1; tick();
        check("ram5_read", 64'(mdr), 64'hDEAD);
        via_inport(32'hBEEF); MDRin = 1; tick();
        Read = 1; MDRin = 1; write = 1; tick();
        check("rdw_old", 64'(mdr), 64'hDEAD);
        Read = 1; MDRin = 1; tick();
        check("rdw_new", 64'(mdr), 64'hBEEF);

        // Clear beats a simultaneous load
        via_inport(32'd77); PCin = 1; Clear = 1'b1; tick();
        Clear = 1'b0;
        for (int i = 0; i < 16; i++) check($sformatf("clr_r%0d", i), 64'(r[i]), 64'd0);
        check("clr_pc", 64'(pc), 64'd0);
        check("clr_ir", 64'(ir), 64'd0);
        check("clr_y", 64'(y), 64'd0);
        check("clr_mar", 64'(mar), 64'd0);
        check("clr_mdr", 64'(mdr), 64'd0);
        check("clr_hi", 64'(hi), 64'd0);
        check("clr_lo", 64'(lo), 64'd0);
        check("clr_z", {zhi, zlo}, 64'd0);
        check("clr_inport", 64'(inport), 64'd0);
        check("clr_outport", 64'(outport), 64'd0);
        check("clr_con", 64'(CON), 64'd0);
        via_inport(32'd5); MARin = 1; tick();
        Read = 1; MDRin = 1; tick();
        check("ram_kept", 64'(mdr), 64'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cpu_datapath.md
Name: bus_cpu_datapath

Overview:
- Single-bus 32-bit CPU datapath.
- Contains:
  - 16-entry register file, plus HI, LO, PC, IR, Y, MAR, MDR, 64-bit Z, inport and outport registers.
  - ALU, select/encode logic, CON flip-flop and a 512x32 RAM.
- An external control unit (or bench) drives every load/drive strobe per T-state; all register contents are exported for observation.

Parameters:
- MEM_DEPTH, 512, RAM words (address = MAR[8:0]).
- BRANCH_OP, 5'b10010, IR[31:27] opcode treated as conditional branch.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  synchronous active-high reset.
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin  in  1 each  load enables.
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout  in  1 each  bus-drive selects.
- OUTPORTout  in  1  outport load enable (captures bus).
- Gra, Grb, Grc, Rin, Rout, BAout  in  1 each  register-select controls.
- Read  in  1  MDR source = RAM when 1, else bus.
- write  in  1  RAM write enable.
- IncPC  in  1  ALU increment mode.
- inportInput  in  32  external input port data.
- regIn  in  16  direct per-register load enables (bit i -> Ri).
- busMuxOut  out  32  bus value.
- encoderOut  out  5  bus select code.
- CON  out  1  branch condition flip-flop.
- BusMuxInR0..BusMuxInR15, BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY  out  32 each  register contents.
- IRregister  out  32  IR.
- Cregister  out  32  sign-extended IR[18:0].
- marToRam  out  9  MAR.

Behaviour:
- Reset:
  - On a rising edge with Clear=1, every register (R0-R15, HI, LO, Z, PC, IR, Y, MAR, MDR, inport, outport, CON) goes to 0.
  - Clear has priority over all loads.
  - RAM is not cleared.
- Registers:
  - Load the bus on the rising edge when their enable is 1.
  - Inport loads inportInput every cycle.
  - MDR loads RAM[MAR] if Read, else bus, when MDRin.
- Select/encode:
  - Field per strobe: Gra->IR[26:23], Grb->IR[22:19], Grc->IR[18:15] (OR of selected fields, one-hot decoded).
  - Ri loads if regIn[i] | (Rin & sel[i]).
  - Ri drives the bus if Rout|BAout and sel[i].
  - With BAout, R0 drives 0.
- Bus encoder:
  - Codes: 0-15 Ri, 16 HI, 17 LO, 18 Zhi, 19 Zlo, 20 PC, 21 MDR, 22 Inport, 23 C, 24 Y.
  - If several sources are asserted, the lowest code wins.
  - If none is asserted, code 19 (Zlo) drives.
  - encoderOut shows the winning code.
- ALU (combinational, captured into Z on Zin):
  - IncPC=1: Zlo=bus+1, Zhi=0.
  - Otherwise operands A=Y, B=bus; operation chosen by IR[31:27]:
    - 00011 add
    - 00100 sub (A-B)
    - 00101 and
    - 00110 or
    - 00111 shr (logical, B[4:0])
    - 01000 shl
    - 01001 neg (-B)
    - 01010 not (~B)
    - 01011 mul: signed 64-bit product, Zhi:Zlo
    - BRANCH_OP: A + (CON ? B : 0)
    - All others (incl. ld/ldi/st 00000-00010): add.
  - Non-mul results: Zhi=0. Arithmetic wraps modulo 2^32.
- CON:
  - On a rising edge with CONin, CON loads a condition of bus per IR[20:19]: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
  - Otherwise CON holds.
- RAM:
  - Asynchronous read of RAM[MAR].
  - Synchronous write RAM[MAR]<=MDR on rising edge when write.
  - Read and write in the same cycle: MDR gets old data.

Optional Feature:
- MEM_INIT_EN defined: RAM is initialised at time zero from hex file "memory.hex" ($readmemh).
- Undefined: RAM initial contents are 0.

Test Plan:
- Inport-to-PC: inportInput=11, INPORTout+PCin one cycle -> BusMuxInPC=11, encoderOut=22.
- Direct register load: inportInput=0, INPORTout, regIn=16'h0040 -> R6=0, other registers unchanged.
- Fetch: RAM[11]=brpl R6,25 (opcode 10010, ra=6, IR[20:19]=10, C=25).
  - T0 PCout,MARin,IncPC,Zin -> MAR=11, Zlo=12.
  - T1 Read,MDRin,PCin -> PC=12, MDR=instruction.
  - T2 MDRout,IRin -> IR loaded, Cregister=25.
- Branch taken:
  - T3 Gra,Rout,CONin -> CON=1 (R6=0).
  - T4 PCout,Yin -> Y=12.
  - T5 Cout,Zin -> Zlo=37.
  - T6 ZLOout,PCin -> PC=37.
- Branch not taken: same sequence with R6=32'h80000000 -> CON=0, final PC=12.
- Reset/memory/mul:
  - Clear=1 mid-sequence -> all registers 0 next edge.
  - MAR=5, MDR=32'hDEAD, write -> RAM[5]=32'hDEAD on readback.
  - mul Y=-3, bus=4 -> Zhi=32'hFFFFFFFF, Zlo=32'hFFFFFFF4.
